maj_net_eval: RTL

MAJ_NET_EVAL -- requirements
Module: maj_net_eval

---
 rtl/maj_net_pkg.sv | 26 ++
 rtl/maj_net_eval_maj3_inv.sv | 19 +
 rtl/maj_net_eval.sv | 131 +++++++++++++
 3 files changed

// File: rtl/maj_net_pkg.sv
// rtl/maj_net_pkg.sv - shared types for the programmable majority network
package maj_net_pkg;

  // Widest operand select carried in the gate table; the top zero-extends into it.
  localparam int SEL_MAX_W = 8;

  localparam logic [SEL_MAX_W-1:0] SEL_CONST0 = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                 inv;
    logic [SEL_MAX_W-1:0] sel;
  } operand_t;

  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } gate_cfg_t;

endpackage

// File: rtl/maj_net_eval_maj3_inv.sv
// rtl/maj_net_eval_maj3_inv.sv - three-input majority gate with per-operand inversion
module maj3_inv (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic inv_a,
  input  logic inv_b,
  input  logic inv_c,
  output logic y
);

  logic aa, bb, cc;

  assign aa = a ^ inv_a;
  assign bb = b ^ inv_b;
  assign cc = c ^ inv_c;
  assign y  = (aa & bb) | (aa & cc) | (bb & cc);

endmodule

// File: rtl/maj_net_eval.sv
// rtl/maj_net_eval.sv - programmable majority-gate network, evaluated one gate per cycle
module maj_net_eval
  import maj_net_pkg::*;
#(
  parameter  int NUM_IN    = 7,
  parameter  int NUM_GATES = 8,
  localparam int SEL_W     = $clog2(1 + NUM_IN + NUM_GATES),
  localparam int GW        = $clog2(NUM_GATES),
  localparam int OPW       = SEL_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [GW-1:0]     cfg_addr,
  input  logic [3*OPW-1:0]  cfg_data,
  input  logic              cfg_len_we,
  input  logic [GW:0]       cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out
);

  state_t                 state, state_nx;
  gate_cfg_t              gtab [NUM_GATES];
  logic [NUM_GATES-1:0]   res;
  logic [NUM_IN-1:0]      xr;
  logic [GW:0]            len;
  logic [GW-1:0]          idx;
  logic                   out_r;
  logic                   last;
  logic                   g_out;
  logic                   op_a, op_b, op_c;
  gate_cfg_t              cur;

  function automatic operand_t unpack_op(input logic [OPW-1:0] f);
    operand_t o;
    o.inv = f[OPW-1];
    o.sel = SEL_MAX_W'(f[SEL_W-1:0]);
    return o;
  endfunction

  // Gate references at or beyond the gate being evaluated read 0, as do unused encodings.
  function automatic logic fetch(input operand_t op, input logic [NUM_IN-1:0] xv,
                                 input logic [NUM_GATES-1:0] rv, input int cur_g);
    logic v;
    v = 1'b0;
    if (op.sel != SEL_CONST0) begin
      for (int i = 0; i < NUM_IN; i++)
        if (int'(op.sel) == i + 1) v = xv[i];
      for (int g = 0; g < NUM_GATES; g++)
        if (int'(op.sel) == NUM_IN + 1 + g && g < cur_g) v = rv[g];
    end
    return v;
  endfunction

  function automatic logic [GW:0] clamp_len(input logic [GW:0] l);
    if (l == '0) return (GW+1)'(1);
    if (int'(l) > NUM_GATES) return (GW+1)'(NUM_GATES);
    return l;
  endfunction

  assign cur  = gtab[idx];
  assign op_a = fetch(cur.a, xr, res, int'(idx));
  assign op_b = fetch(cur.b, xr, res, int'(idx));
  assign op_c = fetch(cur.c, xr, res, int'(idx));
  assign last = ({1'b0, idx} == len - 1'b1);

  maj3_inv u_gate (
    .a     (op_a),
    .b     (op_b),
    .c     (op_c),
    .inv_a (cur.a.inv),
    .inv_b (cur.b.inv),
    .inv_c (cur.c.inv),
    .y     (g_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = EVAL;
      EVAL:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GATES; i++) gtab[i] <= '0;
      len   <= (GW+1)'(1);
      xr    <= '0;
      res   <= '0;
      idx   <= '0;
      out_r <= 1'b0;
    end else begin
      // Config lands on the accepting edge too, so the run it starts already sees it.
      if (state == IDLE) begin
        if (cfg_we && int'(cfg_addr) < NUM_GATES)
          gtab[cfg_addr] <= '{a: unpack_op(cfg_data[0*OPW +: OPW]),
                              b: unpack_op(cfg_data[1*OPW +: OPW]),
                              c: unpack_op(cfg_data[2*OPW +: OPW])};
        if (cfg_len_we) len <= clamp_len(cfg_len);
        if (in_valid) begin
          xr  <= x;
          res <= '0;
          idx <= '0;
        end
      end
      if (state == EVAL) begin
        res[idx] <= g_out;
        if (last) out_r <= g_out;
        else      idx   <= idx + 1'b1;
      end
      if (state == DONE && out_ready) out_r <= 1'b0;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_r && (state == DONE);

endmodule
